// File: rtl/gpc_popcount_seq.sv
// Popcount sequencer: feeds one 16-bit chunk per cycle through a single 16:5 GPC
// and accumulates the partial counts. Define GPC_SKIP_ZERO_EN to skip all-zero chunks.

module core (
  input  logic [15:0] x_i,
  output logic [4:0]  cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int b = 0; b < 16; b++) cnt_o = cnt_o + 5'(x_i[b]);
  end
endmodule

module gpc_popcount_seq #(
  parameter int NUM_CHUNKS = 4,
  parameter int SUM_W      = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [16*NUM_CHUNKS-1:0] in_vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SUM_W-1:0]        out_count,
  output logic                    busy
);
  localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  if (NUM_CHUNKS < 1 || NUM_CHUNKS > 16) begin : g_bad_chunks
    $error("gpc_popcount_seq: NUM_CHUNKS must be in 1..16");
  end
  if ((1 << SUM_W) <= 16 * NUM_CHUNKS) begin : g_bad_sum_w
    $error("gpc_popcount_seq: SUM_W too narrow for 16*NUM_CHUNKS");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                          state_q, state_d;
  logic [SUM_W-1:0]                acc_q, acc_d;
  logic [IDX_W-1:0]                idx_q, idx_d, idx_first, idx_next;
  logic [NUM_CHUNKS-1:0][15:0]     vec_q, vec_d, in_chunks;
  logic                            last, accept;
  logic [15:0]                     gpc_in;
  logic [4:0]                      gpc_cnt;

  assign in_chunks = in_vec;
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign out_count = acc_q;
  assign busy      = (state_q != S_IDLE);

  // GPC sees zeros outside RUN so it does not toggle on idle data
  assign gpc_in = (state_q == S_RUN) ? vec_q[idx_q] : 16'h0000;

  core u_core (.x_i(gpc_in), .cnt_o(gpc_cnt));

`ifdef GPC_SKIP_ZERO_EN
  logic [NUM_CHUNKS-1:0] mask_q, in_nz;

  always_comb begin
    idx_first = '0;
    idx_next  = idx_q;
    last      = 1'b1;
    in_nz     = '0;
    // descending scan so the lowest qualifying chunk wins
    for (int i = NUM_CHUNKS - 1; i >= 0; i--) begin
      in_nz[i] = |in_chunks[i];
      if (|in_chunks[i]) idx_first = IDX_W'(i);
      if (mask_q[i] && (IDX_W'(i) > idx_q)) begin
        idx_next = IDX_W'(i);
        last     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         mask_q <= '0;
    else if (accept) mask_q <= in_nz;
  end
`else
  assign idx_first = '0;
  assign idx_next  = idx_q + 1'b1;
  assign last      = (idx_q == IDX_W'(NUM_CHUNKS - 1));
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          vec_d   = in_chunks;
          acc_d   = '0;
          idx_d   = idx_first;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_q + SUM_W'(gpc_cnt);
        if (last) state_d = S_DONE;
        else      idx_d   = idx_next;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
    end
  end
endmodule

// File: tb/tb_gpc_popcount_seq.sv
// Randomized bench for gpc_popcount_seq against a popcount / chunk-order reference model.
module tb_gpc_popcount_seq;
  localparam int N  = 4;
  localparam int SW = 7;
  localparam int VW = 16 * N;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [VW-1:0] in_vec;
  logic [SW-1:0] out_count;
  int            n_chk = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  gpc_popcount_seq #(.NUM_CHUNKS(N), .SUM_W(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] rnd_vec();
    return {$urandom, $urandom};
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", in_ready, 1);
  endtask

  // Accept one vector, follow it through RUN, hold the result `hold` cycles, then drain.
  task automatic run_vec(input logic [VW-1:0] v, input int hold);
    int          lat;
    logic [15:0] seq[$];
    logic [15:0] exp_q[$];
    logic [15:0] c;
    logic [SW-1:0] held;
    lat = 0;
    for (int k = 0; k < N; k++) begin
      c = v[16*k +: 16];
`ifdef GPC_SKIP_ZERO_EN
      if (c != 16'h0) exp_q.push_back(c);
`else
      exp_q.push_back(c);
`endif
    end
    if (exp_q.size() == 0) exp_q.push_back(16'h0);

    wait_ready();
    in_valid = 1'b1;
    in_vec   = v;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_vec   = rnd_vec();
    forever begin
      @(negedge clk);
      if (out_valid || lat > 40) break;
      seq.push_back(dut.gpc_in);
      lat++;
    end
    chk("latency", lat, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (k < seq.size()) chk("gpc_in_seq", seq[k], exp_q[k]);
    chk("out_count", out_count, $countones(v));
    chk("done_in_ready", in_ready, 0);
    chk("done_busy", busy, 1);
    held = out_count;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_vec   = rnd_vec();
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_count", out_count, held);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_xfer_valid", out_valid, 0);
    chk("post_xfer_busy", busy, 0);
    chk("post_xfer_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] v;
    rst = 1'b1; in_valid = 1'b1; in_vec = '1; out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_count", out_count, 0);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_busy", busy, 0);

    run_vec(64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_vec(64'h0000_FF0F_FFF8_EE40, 0);
    run_vec(64'h0000_FF0F_FFF8_EE40, 5);

    // reset in the second RUN cycle drops the operation
    wait_ready();
    in_valid = 1'b1; in_vec = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_valid", out_valid, 0);
    end
    run_vec(64'h0000_0000_0000_EE40, 0);

    run_vec(64'h0, 1);
    run_vec(64'h0000_FF0F_0000_EE40, 0);
    run_vec(64'h8000_0000_0000_0001, 2);

    for (int i = 0; i < 30; i++) begin
      v = rnd_vec();
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 2) == 0) v[16*k +: 16] = 16'h0;
      run_vec(v, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
